// File: rtl/ahb_slv_pkg.sv
// Shared AHB-Lite encodings, slave state set and bus-geometry helper for the register slave.
// Latency: n/a (types only).  Backpressure: n/a.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_ERR1    = 3'd3,
    ST_ERR2    = 3'd4
  } state_e;

  // Number of byte-offset address bits on a bus of the given data width.
  function automatic int unsigned bus_size_log2(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/ahb_be_gen.sv
// Byte-enable decoder: transfer size plus low address bits to per-lane enables.
// Latency: combinational.  Backpressure: none.
module ahb_be_gen
  import ahb_slv_pkg::*;
#(
  parameter  int AHB_DW = 32,
  localparam int NB     = AHB_DW / 8,
  localparam int BW     = bus_size_log2(AHB_DW)
) (
  input  logic [2:0]    hsize,
  input  logic [BW-1:0] addr_lo,
  output logic [NB-1:0] be
);

  // An offset bit only selects lanes when it lies at or above the transfer size;
  // sizes at or beyond the bus width therefore enable every lane.
  logic [BW-1:0] keep;

  always_comb begin
    keep = '0;
    be   = '0;
    for (int b = 0; b < BW; b++) begin
      keep[b] = (int'(hsize) <= b);
    end
    for (int i = 0; i < NB; i++) begin
      be[i] = ((BW'(i) ^ addr_lo) & keep) == '0;
    end
  end

endmodule

// File: rtl/ahb_reg_slave.sv
// AHB-Lite slave front end for a flat register file with a one-cycle select strobe.
// Latency: writes zero-wait, reads RD_LAT wait states; invalid transfers get a two-cycle ERROR
// when AHB_REG_SLAVE_ERR_EN is defined, else are dropped.  Backpressure: hreadyout_o low in read wait / ERR1.
module ahb_reg_slave
  import ahb_slv_pkg::*;
#(
  parameter int AHB_AW = 32,
  parameter int AHB_DW = 32,
  parameter int RD_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel_i,
  input  logic [AHB_AW-1:0]     haddr_i,
  input  logic                  hwrite_i,
  input  logic [1:0]            htrans_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [AHB_DW-1:0]     hwdata_i,
  input  logic                  hready_i,
  input  logic                  hmastlock_i,
  output logic                  hreadyout_o,
  output logic [1:0]            hresp_o,
  output logic [AHB_DW-1:0]     hrdata_o,
  output logic                  bs_sel_o,
  output logic                  bs_wr_o,
  output logic [AHB_AW-1:0]     bs_addr_o,
  output logic [AHB_DW/8-1:0]   bs_be_o,
  output logic [AHB_DW-1:0]     bs_wdata_o,
  input  logic [AHB_DW-1:0]     rg_rdata_i
);

  localparam int         NB       = AHB_DW / 8;
  localparam int         BW       = bus_size_log2(AHB_DW);
  localparam logic [2:0] MAX_SIZE = 3'(BW);
  localparam logic [2:0] RD_LAST  = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_e        state;
  logic [2:0]    wait_cnt;
  logic          rd_done;
  htrans_e       trans;
  logic          acc;
  logic          addr_ok;
  logic          size_ok;
  logic          acc_ok;
  logic [NB-1:0] be_dec;

  // Bursts are decoded beat by beat and locking has no meaning for a register file.
  logic unused_ok;
  assign unused_ok = ^{hburst_i, hmastlock_i};

  assign trans   = htrans_e'(htrans_i);
  assign acc     = hsel_i && hready_i && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
  assign size_ok = (hsize_i <= MAX_SIZE);
  assign acc_ok  = acc && size_ok && addr_ok;

  always_comb begin
    addr_ok = 1'b1;
    for (int b = 0; b < BW; b++) begin
      if (b < int'(hsize_i) && haddr_i[b]) addr_ok = 1'b0;
    end
  end

`ifdef AHB_REG_SLAVE_ERR_EN
  logic acc_bad;
  assign acc_bad = acc && !(size_ok && addr_ok);
`endif

  ahb_be_gen #(.AHB_DW(AHB_DW)) u_be_gen (
    .hsize   (hsize_i),
    .addr_lo (haddr_i[BW-1:0]),
    .be      (be_dec)
  );

  // Write data is only valid in the data phase, which is exactly the strobe cycle.
  assign bs_wdata_o = hwdata_i;
  assign hrdata_o   = rd_done ? rg_rdata_i : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      rd_done     <= 1'b0;
      hreadyout_o <= 1'b1;
      hresp_o     <= HRESP_OKAY;
      bs_sel_o    <= 1'b0;
      bs_wr_o     <= 1'b0;
      bs_addr_o   <= '0;
      bs_be_o     <= '0;
    end else begin
      bs_sel_o    <= 1'b0;
      bs_wr_o     <= 1'b0;
      bs_be_o     <= '0;
      rd_done     <= 1'b0;
      hresp_o     <= HRESP_OKAY;
      hreadyout_o <= 1'b1;

      // hreadyout_o high means idle or the last data-phase cycle: a new address may land.
      if (hreadyout_o) begin
        state    <= ST_IDLE;
        wait_cnt <= '0;
        if (acc_ok) begin
          bs_sel_o  <= 1'b1;
          bs_wr_o   <= hwrite_i;
          bs_addr_o <= {haddr_i[AHB_AW-1:BW], {BW{1'b0}}};
          bs_be_o   <= hwrite_i ? be_dec : '1;
          if (hwrite_i || RD_LAT == 0) begin
            state   <= ST_DATA;
            rd_done <= !hwrite_i;
          end else begin
            state       <= ST_RD_WAIT;
            hreadyout_o <= 1'b0;
          end
        end
`ifdef AHB_REG_SLAVE_ERR_EN
        else if (acc_bad) begin
          state       <= ST_ERR1;
          hreadyout_o <= 1'b0;
          hresp_o     <= HRESP_ERROR;
        end
`endif
      end else begin
        case (state)
          ST_RD_WAIT: begin
            wait_cnt <= wait_cnt + 3'd1;
            if (wait_cnt == RD_LAST) rd_done <= 1'b1;
            else                     hreadyout_o <= 1'b0;
          end
`ifdef AHB_REG_SLAVE_ERR_EN
          ST_ERR1: begin
            state   <= ST_ERR2;
            hresp_o <= HRESP_ERROR;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Randomised AHB master against ahb_reg_slave (32-bit, RD_LAT=2) with a byte-level memory
// reference model; expected strobes and responses are queued and checked by a separate monitor.
module tb_ahb_reg_slave;

  localparam int RD_LAT = 2;
`ifdef AHB_REG_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel_i;
  logic [31:0] haddr_i;
  logic        hwrite_i;
  logic [1:0]  htrans_i;
  logic [2:0]  hsize_i;
  logic [2:0]  hburst_i;
  logic [31:0] hwdata_i;
  logic        hready_i;
  logic        hmastlock_i;
  logic        hreadyout_o;
  logic [1:0]  hresp_o;
  logic [31:0] hrdata_o;
  logic        bs_sel_o;
  logic        bs_wr_o;
  logic [31:0] bs_addr_o;
  logic [3:0]  bs_be_o;
  logic [31:0] bs_wdata_o;
  logic [31:0] rg_rdata_i;

  always #5 clk = ~clk;
  assign hready_i = hreadyout_o;

  ahb_reg_slave #(.AHB_AW(32), .AHB_DW(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .hsel_i(hsel_i), .haddr_i(haddr_i), .hwrite_i(hwrite_i),
    .htrans_i(htrans_i), .hsize_i(hsize_i), .hburst_i(hburst_i), .hwdata_i(hwdata_i),
    .hready_i(hready_i), .hmastlock_i(hmastlock_i), .hreadyout_o(hreadyout_o),
    .hresp_o(hresp_o), .hrdata_o(hrdata_o), .bs_sel_o(bs_sel_o), .bs_wr_o(bs_wr_o),
    .bs_addr_o(bs_addr_o), .bs_be_o(bs_be_o), .bs_wdata_o(bs_wdata_o), .rg_rdata_i(rg_rdata_i)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } strb_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
    string       name;
  } rsp_t;

  strb_t       strb_q[$];
  rsp_t        rsp_q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          strobes = 0;
  logic [7:0]  ref_mem[256];
  logic [7:0]  rf_mem[256];
  logic [31:0] pend_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: a transfer is a byte-range access into a flat memory.
  task automatic model(input logic wr, input logic [7:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input string nm);
    int    nbytes;
    int    base;
    int    off;
    bit    ok;
    rsp_t  r;
    strb_t s;
    nbytes  = 1 << size;
    base    = int'(addr) & 'hFC;
    off     = int'(addr) % 4;
    ok      = (size <= 3'd2) && (int'(addr) % nbytes == 0);
    r.name  = nm;
    r.rdata = '0;
    if (!ok) begin
      r.err   = ERR_EN;
      r.waits = ERR_EN ? 1 : 0;
      rsp_q.push_back(r);
      return;
    end
    r.err  = 1'b0;
    s.wr   = wr;
    s.addr = 32'(base);
    if (wr) begin
      s.be    = '0;
      s.wdata = wdata;
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + nbytes) begin
          s.be[b]           = 1'b1;
          ref_mem[base + b] = wdata[8*b +: 8];
        end
      end
      r.waits = 0;
    end else begin
      s.be    = 4'hF;
      s.wdata = '0;
      r.rdata = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      r.waits = RD_LAT;
    end
    strb_q.push_back(s);
    rsp_q.push_back(r);
  endtask

  // One address phase; called just after the edge that accepted the previous one.
  task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr, input logic [7:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata, input string nm);
    int n;
    n        = 0;
    hwdata_i = pend_wdata;
    hsel_i   = sel;
    htrans_i = tr;
    hwrite_i = wr;
    haddr_i  = {24'h0, addr};
    hsize_i  = size;
    forever begin
      @(negedge clk);
      if (hreadyout_o) break;
      n++;
      if (n > 32) begin
        checks++;
        errors++;
        $display("FAIL %s hready_timeout: got 0 expected 1", nm);
        break;
      end
    end
    if (sel && tr[1]) model(wr, addr, size, wdata, nm);
    pend_wdata = wr ? wdata : $urandom;
    @(posedge clk);
    #1;
  endtask

  // Register file: applies write strobes, latches read data on read strobes.
  always @(negedge clk) begin
    logic [7:0] a;
    if (rst_n && bs_sel_o) begin
      a = bs_addr_o[7:0];
      if (bs_wr_o) begin
        for (int b = 0; b < 4; b++)
          if (bs_be_o[b]) rf_mem[8'(a + 8'(b))] = bs_wdata_o[8*b +: 8];
      end else begin
        rg_rdata_i = {rf_mem[8'(a + 8'd3)], rf_mem[8'(a + 8'd2)], rf_mem[8'(a + 8'd1)], rf_mem[a]};
      end
    end
  end

  // Monitor: pops expected strobes and data-phase responses as the DUT presents them.
  logic in_dp = 1'b0;
  int   wait_n = 0;
  always @(negedge clk) begin
    strb_t s;
    rsp_t  r;
    if (!rst_n) begin
      in_dp  = 1'b0;
      wait_n = 0;
      rsp_q.delete();
    end else begin
      if (bs_sel_o) begin
        strobes++;
        if (strb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got addr %h expected no strobe", bs_addr_o);
        end else begin
          s = strb_q.pop_front();
          chk("strobe_wr", {31'h0, bs_wr_o}, {31'h0, s.wr});
          chk("strobe_addr", bs_addr_o, s.addr);
          chk("strobe_be", {28'h0, bs_be_o}, {28'h0, s.be});
          if (s.wr) chk("strobe_wdata", bs_wdata_o, s.wdata);
        end
      end
      if (in_dp) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_data_phase: got response expected none");
          in_dp = 1'b0;
        end else if (!hreadyout_o) begin
          wait_n++;
          chk({rsp_q[0].name, "_wait_hresp"}, {30'h0, hresp_o}, rsp_q[0].err ? 32'd1 : 32'd0);
          chk({rsp_q[0].name, "_wait_hrdata"}, hrdata_o, 32'h0);
        end else begin
          r = rsp_q.pop_front();
          chk({r.name, "_hresp"}, {30'h0, hresp_o}, r.err ? 32'd1 : 32'd0);
          chk({r.name, "_hrdata"}, hrdata_o, r.rdata);
          chk({r.name, "_waits"}, 32'(wait_n), 32'(r.waits));
          in_dp = 1'b0;
        end
      end
      if (hreadyout_o) begin
        in_dp  = hsel_i && htrans_i[1];
        wait_n = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0;
    logic [2:0]  sz;
    logic [7:0]  ad;
    logic [1:0]  tr;
    logic [2:0]  sizes[6];
    sizes = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i * 37 + 5);
      rf_mem[i]  = 8'(i * 37 + 5);
    end
    rst_n = 1'b0; hsel_i = 1'b0; haddr_i = '0; hwrite_i = 1'b0; htrans_i = 2'b00;
    hsize_i = 3'd2; hburst_i = 3'd0; hwdata_i = '0; hmastlock_i = 1'b0;
    rg_rdata_i = '0; pend_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout", {31'h0, hreadyout_o}, 32'd1);
    chk("rst_hresp", {30'h0, hresp_o}, 32'd0);
    chk("rst_bs_sel", {31'h0, bs_sel_o}, 32'd0);
    chk("rst_bs_wr", {31'h0, bs_wr_o}, 32'd0);
    chk("rst_bs_addr", bs_addr_o, 32'd0);
    chk("rst_bs_be", {28'h0, bs_be_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    xfer(1, 2'b10, 1, 8'h10, 3'd2, 32'hA5A5_1234, "wr_word");
    xfer(1, 2'b10, 1, 8'h13, 3'd0, 32'h7700_0000, "wr_byte");
    xfer(1, 2'b10, 1, 8'h12, 3'd1, 32'h5566_0000, "wr_half");
    xfer(1, 2'b10, 1, 8'h20, 3'd2, 32'hDEAD_BEEF, "wr_20");
    xfer(1, 2'b10, 0, 8'h20, 3'd2, 32'h0, "rd_20");
    xfer(1, 2'b10, 0, 8'h10, 3'd2, 32'h0, "rd_10");
    xfer(1, 2'b10, 0, 8'h22, 3'd2, 32'h0, "rd_misaligned");
    xfer(1, 2'b10, 1, 8'h31, 3'd1, 32'h1234_5678, "wr_misaligned");
    xfer(0, 2'b10, 1, 8'h30, 3'd2, 32'h1111_2222, "unselected");
    xfer(1, 2'b00, 0, 8'h30, 3'd2, 32'h0, "idle");

    s0 = strobes;
    hburst_i = 3'b011;
    xfer(1, 2'b10, 1, 8'h40, 3'd2, $urandom, "burst0");
    xfer(1, 2'b11, 1, 8'h44, 3'd2, $urandom, "burst1");
    xfer(1, 2'b01, 1, 8'h48, 3'd2, $urandom, "busy");
    xfer(1, 2'b11, 1, 8'h48, 3'd2, $urandom, "burst2");
    xfer(1, 2'b11, 1, 8'h4C, 3'd2, $urandom, "burst3");
    hburst_i = 3'b000;
    xfer(1, 2'b00, 0, 8'h00, 3'd2, 32'h0, "idle");
    repeat (2) @(posedge clk);
    #1;
    chk("burst_strobes", 32'(strobes - s0), 32'd4);

    xfer(1, 2'b10, 0, 8'h44, 3'd2, 32'h0, "rd_abort");
    hsel_i = 1'b0;
    htrans_i = 2'b00;
    @(negedge clk);
    chk("abort_in_wait", {31'h0, hreadyout_o}, 32'd0);
    @(posedge clk);
    #1;
    s0 = strobes;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_hreadyout", {31'h0, hreadyout_o}, 32'd1);
    chk("abort_bs_sel", {31'h0, bs_sel_o}, 32'd0);
    chk("abort_hrdata", hrdata_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_strobe", 32'(strobes), 32'(s0));

    for (int n = 0; n < 300; n++) begin
      sz = sizes[$urandom_range(0, 5)];
      ad = 8'($urandom);
      if ($urandom_range(0, 3) != 0) ad = ad & ~8'((1 << sz) - 1);
      case ($urandom_range(0, 7))
        0:       tr = 2'b00;
        1:       tr = 2'b01;
        2, 3, 4: tr = 2'b10;
        default: tr = 2'b11;
      endcase
      xfer($urandom_range(0, 7) != 0, tr, 1'($urandom), ad, sz, $urandom, "rnd");
    end
    xfer(1, 2'b00, 0, 8'h00, 3'd2, 32'h0, "idle");
    repeat (6) @(posedge clk);
    #1;
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("strb_q_drained", 32'(strb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
